// File: rtl/fma_queue_pkg.sv
// Shared types and constants for the FMA result queue.
package fma_queue_pkg;

  localparam int unsigned FMA_REC_W  = 33;
  localparam int unsigned FMA_FLAG_W = 5;
  localparam int unsigned FMA_TAG_W  = 5;

  localparam int unsigned FLAG_NV = 4;
  localparam int unsigned FLAG_DZ = 3;
  localparam int unsigned FLAG_OF = 2;
  localparam int unsigned FLAG_UF = 1;
  localparam int unsigned FLAG_NX = 0;

  typedef struct packed {
    logic [FMA_REC_W-1:0]  data;
    logic [FMA_FLAG_W-1:0] flags;
    logic [FMA_TAG_W-1:0]  tag;
  } fma_result_t;

  // A clear coinciding with a dequeue keeps only the dequeued entry's flags.
  function automatic logic [FMA_FLAG_W-1:0] merge_fflags(
    input logic [FMA_FLAG_W-1:0] cur,
    input logic [FMA_FLAG_W-1:0] deq_flags,
    input logic                  deq_fire,
    input logic                  clr
  );
    logic [FMA_FLAG_W-1:0] add;
    add = deq_fire ? deq_flags : '0;
    return clr ? add : (cur | add);
  endfunction

endpackage

// File: rtl/fma_result_fifo.sv
// Ring-buffer FIFO; when empty the read port holds the last head shown.
module fma_result_fifo
  import fma_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type         T     = fma_result_t
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   wr_en,
  input  T                       wr_data,
  input  logic                   rd_en,
  output T                       rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  T                 mem_q [DEPTH];
  T                 hold_q, hold_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_wr, do_rd;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_CNT);
  assign count   = count_q;
  assign rd_data = empty ? hold_q : mem_q[rd_ptr_q];

  always_comb begin
    do_rd    = rd_en && !empty;
    do_wr    = wr_en && !clr && (!full || do_rd);
    wr_ptr_d = wr_ptr_q + PTR_W'(do_wr);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_rd);
    count_d  = count_q + CNT_W'(do_wr) - CNT_W'(do_rd);
    hold_d   = empty ? hold_q : mem_q[rd_ptr_q];
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      hold_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      hold_q   <= hold_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/fma_result_queue.sv
// Credit-based result capture behind a fixed-latency, non-stallable FMA pipe:
// shadow tag pipe, result FIFO, sticky fflags and protocol error.
module fma_result_queue
  import fma_queue_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned PIPE_LAT = 2,
  parameter int unsigned TAG_W    = FMA_TAG_W
) (
  input  logic                   clock,
  input  logic                   reset,
  output logic                   io_issue_ready,
  input  logic                   io_issue_valid,
  input  logic [TAG_W-1:0]       io_issue_tag,
  input  logic                   io_fma_validout,
  input  logic [FMA_REC_W-1:0]   io_fma_out,
  input  logic [FMA_FLAG_W-1:0]  io_fma_flags,
  output logic                   io_deq_valid,
  input  logic                   io_deq_ready,
  output logic [FMA_REC_W-1:0]   io_deq_data,
  output logic [FMA_FLAG_W-1:0]  io_deq_flags,
  output logic [TAG_W-1:0]       io_deq_tag,
  input  logic                   io_flush,
  input  logic                   io_fflags_clear,
  output logic [FMA_FLAG_W-1:0]  io_fflags,
  output logic [$clog2(DEPTH):0] io_count,
  output logic                   io_error
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  // Package type fixes the tag at FMA_TAG_W; this one follows TAG_W.
  typedef struct packed {
    logic [FMA_REC_W-1:0]  data;
    logic [FMA_FLAG_W-1:0] flags;
    logic [TAG_W-1:0]      tag;
  } entry_t;

  logic [CNT_W-1:0]      credits_q, credits_d;
  logic [PIPE_LAT-1:0]   vld_q, vld_d;
  logic [PIPE_LAT-1:0]   live_q, live_d;
  logic [TAG_W-1:0]      tag_q [PIPE_LAT];
  logic [TAG_W-1:0]      tag_d [PIPE_LAT];
  logic [FMA_FLAG_W-1:0] fflags_q, fflags_d;
  logic                  error_q, error_d;

  logic   fire, deq_fire, last_vld, last_live, capture, overflow;
  logic   fifo_full, fifo_empty;
  entry_t wr_entry, head;

  assign io_issue_ready = (credits_q != '0) && !io_flush;
  assign fire           = io_issue_valid && io_issue_ready;
  assign io_deq_valid   = !fifo_empty;
  assign deq_fire       = io_deq_valid && io_deq_ready;
  assign last_vld       = vld_q[PIPE_LAT-1];
  assign last_live      = live_q[PIPE_LAT-1];
  assign capture        = io_fma_validout && last_vld && last_live && !io_flush;
  assign overflow       = capture && fifo_full && !deq_fire;

  assign wr_entry = '{data: io_fma_out, flags: io_fma_flags, tag: tag_q[PIPE_LAT-1]};

  fma_result_fifo #(
    .DEPTH (DEPTH),
    .T     (entry_t)
  ) u_fifo (
    .clk     (clock),
    .rst_n   (reset),
    .clr     (io_flush),
    .wr_en   (capture),
    .wr_data (wr_entry),
    .rd_en   (io_deq_ready),
    .rd_data (head),
    .count   (io_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign io_deq_data  = head.data;
  assign io_deq_flags = head.flags;
  assign io_deq_tag   = head.tag;
  assign io_fflags    = fflags_q;
  assign io_error     = error_q;

  always_comb begin
    vld_d[0]  = fire;
    live_d[0] = fire;
    tag_d[0]  = io_issue_tag;
    // Flush kills in-flight ops but keeps vld so a missing result is still flagged.
    for (int unsigned i = 1; i < PIPE_LAT; i++) begin
      vld_d[i]  = vld_q[i-1];
      live_d[i] = live_q[i-1] && !io_flush;
      tag_d[i]  = tag_q[i-1];
    end

    credits_d = io_flush ? CNT_W'(DEPTH)
                         : credits_q - CNT_W'(fire) + CNT_W'(deq_fire);

    fflags_d = merge_fflags(fflags_q, io_deq_flags, deq_fire, io_fflags_clear);

    error_d = error_q
            | (io_issue_valid && !io_issue_ready)
            | (io_fma_validout && !last_vld)
            | (last_vld && !io_fma_validout)
            | overflow;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      credits_q <= CNT_W'(DEPTH);
      vld_q     <= '0;
      live_q    <= '0;
      for (int unsigned i = 0; i < PIPE_LAT; i++) tag_q[i] <= '0;
      fflags_q  <= '0;
      error_q   <= 1'b0;
    end else begin
      credits_q <= credits_d;
      vld_q     <= vld_d;
      live_q    <= live_d;
      for (int unsigned i = 0; i < PIPE_LAT; i++) tag_q[i] <= tag_d[i];
      fflags_q  <= fflags_d;
      error_q   <= error_d;
    end
  end

endmodule
